data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the CPU data-memory interface: accepts one load/store request at a time over a valid/ready handshake. It waits a configurable number of cycles, performs the word access on internal storage, and returns read data or a write acknowledge over a second valid/ready channel. It sits where the CPU's combinational data memory sits today, so a multi-cycle or stalled core can be verified against a memory that does not answer in zero time.

## Interface
- DEPTH, 64: number of 32-bit words of storage; power of two, ≥2.
- WAIT, 2: wait-state cycles inserted between request acceptance and the access; range 0..15.
- CLK  in  1  single clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write, addr, wdata.
  - Load the wait counter with WAIT.
  - Go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle while nonzero.
  - On the edge where the counter is 0, perform the access, register rsp_rdata/rsp_err, set rsp_valid, and go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - A new request cannot be accepted in this cycle.
- Address decode:
  - word index = addr[log2(DEPTH)+1:2].
  - Error if addr[1:0]≠0.
  - Error if addr[31:log2(DEPTH)+2]≠0.
- Error access: no storage write, rsp_rdata=0, rsp_err=1.
- Store: writes wdata to the word at the access edge; rsp_rdata=0, rsp_err=0.
- Load: rsp_rdata = stored word at the access edge.
- Requester inputs are ignored outside IDLE. Changing them after acceptance has no effect.

## Timing
- Reset (asynchronous, Reset=0) sets:
  - state IDLE and counter 0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - all storage words cleared to 0.
- Latency: request accepted at edge t → rsp_valid high after edge t+WAIT+1.
  - WAIT=0: response is visible the cycle after acceptance.
- Throughput with rsp_ready held high: one transaction per WAIT+3 cycles.
- Reset asserted in WAIT, before the access edge: the transaction is dropped and no write commits.
- Reset asserted in RESP: the pending response is discarded.
- rsp_ready high while rsp_valid=0 has no effect.
- Read-after-write to the same address: the load returns the new data, since the store committed in an earlier transaction.
- No combinational path from any input to any output. req_ready and busy are decoded from registered state only.

## Structure
- Package mem_pkg holds:
  - state enum (IDLE, WAIT, RESP).
  - WORD_W=32.
  - the address-decode/error function, shared with the instruction-side responder planned next.
- Sub-module mem_array:
  - DEPTH×32 storage with write enable and asynchronous read.
  - clear-on-reset.
  - instantiated once.
- FSM, wait counter and response registers live in the top module.

## Test plan
- Reset, then store 0xDEADBEEF to addr 0x10 with WAIT=2. Required:
  - rsp_valid rises exactly 3 cycles after acceptance.
  - rsp_err=0, rsp_rdata=0.
  - A following load from 0x10 returns 0xDEADBEEF.
- Load from 0x12. Required: rsp_err=1, rsp_rdata=0, storage unchanged.
- Load from 0x100 with DEPTH=64. Required: rsp_err=1, rsp_rdata=0.
- Backpressure: hold rsp_ready=0 for 5 cycles. Required:
  - rsp_valid and rsp_rdata stable throughout.
  - req_ready=0 throughout, even with req_valid=1.
  - After rsp_ready=1, returns to IDLE in one cycle.
- WAIT=0 back-to-back with rsp_ready=1. Required:
  - Store 0x1 to 0x0, then load from 0x0 → 0x1.
  - Acceptances exactly 3 cycles apart.
- Assert Reset mid-WAIT during a store of 0x55 to 0x4. Required:
  - Outputs return to reset values immediately.
  - A later load from 0x4 returns 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-side memory responders: word width,
// responder state encoding and the byte-address decode check.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Misaligned, or any bit set above the word index of a DEPTH=2**aw array.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned      aw);
    logic [WORD_W-1:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between a CPU data port (master)
// and a memory responder (slave).
interface data_mem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_array.sv
// DEPTH x WORD_W storage: one synchronous write port, asynchronous read on
// the same index, every word cleared by reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT cycles, performs
// the word access and holds the response until the requester takes it.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);

  state_t            state;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic [WORD_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              err;
  logic              access;
  logic              mem_we;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] mem_rdata;

  // Decode works only on the latched request, so later input changes are inert.
  assign err    = addr_err(addr_q, AW);
  assign idx    = addr_q[AW+1:2];
  assign access = (state == S_WAIT) && (cnt == 4'd0);
  assign mem_we = access && wr_q && !err;

  mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .addr  (idx),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt     <= 4'(WAIT);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_err_q   <= err;
            rsp_rdata_q <= (err || wr_q) ? '0 : mem_rdata;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table vectors, directed corner sequences and
// random traffic checked against a word-array memory model.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int WAITA = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_a, busy_b;

  always #5 clk = ~clk;

  data_mem_responder_if ia();
  data_mem_responder_if ib();

  data_mem_responder #(.DEPTH(DEPTH), .WAIT(WAITA)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .busy(busy_a));

  data_mem_responder #(.DEPTH(DEPTH), .WAIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .busy(busy_b));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] model [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Model: expected response from plain address arithmetic on a word array.
  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
    err   = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
    rdata = 32'h0;
    if (!err) begin
      if (wr) model[addr / 4] = wdata;
      else    rdata = model[addr / 4];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    ia.req_write = wr; ia.req_addr = addr; ia.req_wdata = wdata; ia.req_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the latched request must win.
    ia.req_valid = 1'b0; ia.req_write = ~wr; ia.req_addr = $urandom; ia.req_wdata = $urandom;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ia.rsp_valid) begin lat = k; break; end
    end
    rdata = ia.rsp_rdata;
    err   = ia.rsp_err;
    ia.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ia.rsp_ready = 1'b0;
  endtask

  task automatic run_check(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_txn(wr, addr, wdata, rd, er, lat);
    chk({name, ".rdata"}, rd, exp_rdata);
    chk({name, ".err"}, {31'h0, er}, {31'h0, exp_err});
    chk({name, ".latency"}, 32'(lat), 32'(WAITA + 1));
  endtask

  initial begin
    vec_t tbl [9];
    logic [31:0] erd, addr, wd;
    logic        eer, wr;
    int          acc [$];
    int          rsp_cyc [$];
    logic [31:0] rds [$];
    logic        ers [$];
    logic        acc_now, rsp_now;
    int          seen;

    tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 32'h12,  32'h0,        32'h0,        1'b1};
    tbl[3] = '{1'b0, 32'h100, 32'h0,        32'h0,        1'b1};
    tbl[4] = '{1'b1, 32'h12,  32'h11111111, 32'h0,        1'b1};
    tbl[5] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[6] = '{1'b1, 32'hFC,  32'h0000CAFE, 32'h0,        1'b0};
    tbl[7] = '{1'b0, 32'hFC,  32'h0,        32'h0000CAFE, 1'b0};
    tbl[8] = '{1'b0, 32'h0,   32'h0,        32'h0,        1'b0};

    ia.req_valid = 1'b0; ia.req_write = 1'b0; ia.req_addr = '0; ia.req_wdata = '0; ia.rsp_ready = 1'b0;
    ib.req_valid = 1'b0; ib.req_write = 1'b0; ib.req_addr = '0; ib.req_wdata = '0; ib.rsp_ready = 1'b0;
    model_clear();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.req_ready", {31'h0, ia.req_ready}, 32'h1);
    chk("reset.rsp_valid", {31'h0, ia.rsp_valid}, 32'h0);
    chk("reset.rsp_rdata", ia.rsp_rdata, 32'h0);
    chk("reset.rsp_err",   {31'h0, ia.rsp_err}, 32'h0);
    chk("reset.busy",      {31'h0, busy_a}, 32'h0);

    // WAIT=0 back-to-back: store 1 to 0x0 then load it, rsp_ready held high.
    ib.rsp_ready = 1'b1;
    @(negedge clk);
    ib.req_write = 1'b1; ib.req_addr = 32'h0; ib.req_wdata = 32'h1; ib.req_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      acc_now = ib.req_valid && ib.req_ready;
      rsp_now = ib.rsp_valid;
      if (acc_now) acc.push_back(cyc);
      if (rsp_now) begin rsp_cyc.push_back(cyc); rds.push_back(ib.rsp_rdata); ers.push_back(ib.rsp_err); end
      @(posedge clk); #1;
      if (acc_now) begin
        if (acc.size() == 1) begin ib.req_write = 1'b0; ib.req_wdata = 32'hFFFFFFFF; end
        else ib.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    ib.rsp_ready = 1'b0;
    chk("w0.accept_count", 32'(acc.size()), 32'd2);
    chk("w0.resp_count", 32'(rsp_cyc.size()), 32'd2);
    if (acc.size() == 2 && rsp_cyc.size() == 2) begin
      chk("w0.accept_gap", 32'(acc[1] - acc[0]), 32'd3);
      chk("w0.store_latency", 32'(rsp_cyc[0] - acc[0]), 32'd2);
      chk("w0.store_rdata", rds[0], 32'h0);
      chk("w0.store_err", {31'h0, ers[0]}, 32'h0);
      chk("w0.load_rdata", rds[1], 32'h1);
      chk("w0.load_err", {31'h0, ers[1]}, 32'h0);
    end

    for (int i = 0; i < 9; i++) begin
      model_access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, erd, eer);
      run_check($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                tbl[i].exp_rdata, tbl[i].exp_err);
    end

    // Backpressure: response held 5 cycles, new request ignored meanwhile.
    @(negedge clk);
    ia.req_write = 1'b0; ia.req_addr = 32'h10; ia.req_valid = 1'b1;
    @(posedge clk); #1;
    ia.req_addr = 32'h20; ia.req_write = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ia.rsp_valid) begin seen = 1; break; end
    end
    chk("bp.rsp_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.rsp_valid%0d", i), {31'h0, ia.rsp_valid}, 32'h1);
      chk($sformatf("bp.rsp_rdata%0d", i), ia.rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp.req_ready%0d", i), {31'h0, ia.req_ready}, 32'h0);
    end
    ia.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ia.rsp_ready = 1'b0; ia.req_valid = 1'b0;
    chk("bp.idle_req_ready", {31'h0, ia.req_ready}, 32'h1);
    chk("bp.idle_rsp_valid", {31'h0, ia.rsp_valid}, 32'h0);
    chk("bp.idle_busy", {31'h0, busy_a}, 32'h0);
    run_check("bp.noaccept", 1'b0, 32'h20, 32'h0, model[32'h20 / 4], 1'b0);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      wr = 1'(($urandom & 1));
      wd = $urandom;
      if (r < 7)       addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (r == 7) addr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 8) addr = $urandom | 32'h100;
      else             addr = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
      model_access(wr, addr, wd, erd, eer);
      run_check($sformatf("rnd%0d", i), wr, addr, wd, erd, eer);
    end

    // Reset in the middle of the wait: the store must not commit.
    @(negedge clk);
    ia.req_write = 1'b1; ia.req_addr = 32'h4; ia.req_wdata = 32'h55; ia.req_valid = 1'b1;
    @(posedge clk); #1;
    ia.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.req_ready", {31'h0, ia.req_ready}, 32'h1);
    chk("midrst.rsp_valid", {31'h0, ia.rsp_valid}, 32'h0);
    chk("midrst.busy", {31'h0, busy_a}, 32'h0);
    chk("midrst.rsp_rdata", ia.rsp_rdata, 32'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    run_check("midrst.load4", 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
    run_check("midrst.load10", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
